// File: rtl/pci_pkg.sv
// pci_pkg: shared PCI initiator constants, command codes, state and status types.
package pci_pkg;
    localparam int MAX_BURST  = 16;
    localparam int DEVSEL_TMO = 5;
    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;
    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, TURN} state_t;
    typedef enum logic [1:0] {STAT_OK = 2'b00, STAT_ABORT = 2'b01, STAT_STOP = 2'b10} status_t;
    function automatic logic is_write(input logic [3:0] c);
        return c == CMD_MEM_WR;
    endfunction
endpackage

// File: rtl/pci_devsel_timer.sv
// pci_devsel_timer: DEVSEL# claim timer; loaded in the address phase, flags a timeout when no target responds.
module pci_devsel_timer
    import pci_pkg::*;
#(
    parameter int TMO = DEVSEL_TMO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    input  logic devsel_n,
    output logic timeout
);
    localparam int W = $clog2(TMO + 1);
    logic [W-1:0] cnt;
    // the address cycle is the first counted cycle, hence the TMO-1 preload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= W'(TMO - 1);
        else if (run && !devsel_n) cnt <= '0;
        else if (run && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign timeout = run && devsel_n && cnt == W'(1);
endmodule

// File: rtl/pci_initiator.sv
// pci_initiator: PCI bus master (REQ/GNT, address phase, 1-16 data phases).
// Master abort on missing DEVSEL# is built only with PCI_INIT_MASTER_ABORT_EN.
module pci_initiator
    import pci_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [31:0] addr,
    input  logic [3:0]  len,
    input  logic [31:0] wr_data,
    output logic        wr_pop,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic        REQ,
    input  logic        GNT,
    input  logic        FRAME_in,
    input  logic        IRDY_in,
    input  logic        TRDY,
    input  logic        DEVSEL,
    input  logic        STOP,
    output logic        FRAME_out,
    output logic        IRDY_out,
    output logic        fi_oe,
    output logic [31:0] ad_out,
    input  logic [31:0] ad_in,
    output logic        ad_oe,
    output logic [3:0]  cbe_out
);
    localparam int CW = $clog2(MAX_BURST);
    state_t state, state_nx;
    logic [3:0] cmd_q, len_q;
    logic [31:0] addr_q;
    logic [CW-1:0] cnt;
    logic wr, xfer, last, abort;

`ifdef PCI_INIT_MASTER_ABORT_EN
    pci_devsel_timer #(.TMO(DEVSEL_TMO)) u_devsel_timer (
        .clk(clk),
        .rst_n(rst_n),
        .load(state == ADDR),
        .run(state == DATA),
        .devsel_n(DEVSEL),
        .timeout(abort)
    );
`else
    logic unused_devsel;
    assign unused_devsel = DEVSEL;
    assign abort = 1'b0;
`endif

    assign wr   = is_write(cmd_q);
    assign last = cnt == CW'(len_q);
    assign xfer = state == DATA && !TRDY && !abort;
    assign busy = state != IDLE || done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:         state_nx = (start && !done) ? pci_pkg::REQ : IDLE;
            pci_pkg::REQ: state_nx = (!GNT && FRAME_in && IRDY_in) ? ADDR : pci_pkg::REQ;
            ADDR:         state_nx = DATA;
            DATA:         state_nx = (abort || !STOP || (xfer && last)) ? TURN : DATA;
            TURN:         state_nx = IDLE;
            default:      state_nx = IDLE;
        endcase
    end

    // FRAME# rises as the last data phase begins; reads leave AD to the target
    always_comb begin
        REQ       = state != pci_pkg::REQ;
        FRAME_out = !(state == ADDR || (state == DATA && !last));
        IRDY_out  = state != DATA;
        fi_oe     = state == ADDR || state == DATA || state == TURN;
        ad_oe     = state == ADDR || (state == DATA && wr);
        ad_out    = state == ADDR ? addr_q : (state == DATA && wr) ? wr_data : 32'h0;
        cbe_out   = state == ADDR ? cmd_q : state == DATA ? 4'b0000 : 4'b1111;
        wr_pop    = xfer && wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            status   <= STAT_OK;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (state == IDLE && start && !done) begin
                cmd_q  <= cmd;
                addr_q <= addr;
                len_q  <= len;
                status <= STAT_OK;
            end
            cnt      <= state == ADDR ? '0 : xfer ? cnt + 1'b1 : cnt;
            done     <= state == TURN;
            rd_valid <= xfer && !wr;
            if (xfer && !wr) rd_data <= ad_in;
            if (state == DATA && state_nx == TURN)
                status <= abort ? STAT_ABORT : !STOP ? STAT_STOP : STAT_OK;
        end
    end
endmodule

// File: tb/tb_pci_initiator.sv
// tb_pci_initiator: directed self-checking bench for pci_initiator.
module tb_pci_initiator;
    logic        clk = 0, rst_n = 0, start = 0;
    logic [3:0]  cmd = 0, len = 0;
    logic [31:0] addr = 0, wr_data = 0, ad_in = 0;
    logic        GNT = 1, FRAME_in = 1, IRDY_in = 1, TRDY = 1, DEVSEL = 1, STOP = 1;
    logic        wr_pop, rd_valid, busy, done, REQ, FRAME_out, IRDY_out, fi_oe, ad_oe;
    logic [31:0] rd_data, ad_out;
    logic [1:0]  status;
    logic [3:0]  cbe_out;
    int checks = 0, failures = 0;
    int n_pop = 0, n_rd = 0, n_fl = 0, n_il = 0;
    int b_pop, b_rd, b_fl, b_il;

    pci_initiator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .addr(addr), .len(len),
        .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .status(status), .REQ(REQ), .GNT(GNT),
        .FRAME_in(FRAME_in), .IRDY_in(IRDY_in), .TRDY(TRDY), .DEVSEL(DEVSEL), .STOP(STOP),
        .FRAME_out(FRAME_out), .IRDY_out(IRDY_out), .fi_oe(fi_oe), .ad_out(ad_out),
        .ad_in(ad_in), .ad_oe(ad_oe), .cbe_out(cbe_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pop) n_pop++;
        if (rd_valid) n_rd++;
        if (!FRAME_out && fi_oe) n_fl++;
        if (!IRDY_out && fi_oe) n_il++;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", done, 1);
    endtask

    initial begin
        tick(); tick();
        chk("rst_req", REQ, 1);
        chk("rst_frame", FRAME_out, 1);
        chk("rst_irdy", IRDY_out, 1);
        chk("rst_fi_oe", fi_oe, 0);
        chk("rst_ad_oe", ad_oe, 0);
        chk("rst_ad_out", ad_out, 0);
        chk("rst_cbe", cbe_out, 4'hF);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_wr_pop", wr_pop, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1;
        tick();

        // single-phase write
        b_pop = n_pop;
        cmd = 4'h7; addr = 32'h1000; len = 0; wr_data = 32'hDEAD0001; start = 1;
        tick(); start = 0;
        chk("t1_req", REQ, 0);
        chk("t1_busy", busy, 1);
        chk("t1_frame_wait", FRAME_out, 1);
        GNT = 0;
        tick();
        chk("t1_addr", ad_out, 32'h1000);
        chk("t1_addr_cbe", cbe_out, 4'h7);
        chk("t1_addr_frame", FRAME_out, 0);
        chk("t1_addr_req", REQ, 1);
        chk("t1_addr_ad_oe", ad_oe, 1);
        chk("t1_addr_fi_oe", fi_oe, 1);
        GNT = 1; DEVSEL = 0; TRDY = 0;
        tick();
        chk("t1_data_irdy", IRDY_out, 0);
        chk("t1_data_frame", FRAME_out, 1);
        chk("t1_data_ad", ad_out, 32'hDEAD0001);
        chk("t1_data_cbe", cbe_out, 4'h0);
        chk("t1_wr_pop", wr_pop, 1);
        tick();
        DEVSEL = 1; TRDY = 1;
        chk("t1_turn_frame", FRAME_out, 1);
        chk("t1_turn_irdy", IRDY_out, 1);
        chk("t1_turn_fi_oe", fi_oe, 1);
        chk("t1_turn_done", done, 0);
        chk("t1_turn_pop", wr_pop, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_status", status, 2'b00);
        chk("t1_rel_fi_oe", fi_oe, 0);
        chk("t1_done_busy", busy, 1);
        chk("t1_pops", n_pop - b_pop, 1);
        start = 1; addr = 32'h5555;
        tick(); start = 0;
        chk("t1_after_done", done, 0);
        chk("t1_idle_busy", busy, 0);
        tick();
        chk("t1_ignored_start", REQ, 1);

        // 4-phase read with two wait states on phase 2
        b_rd = n_rd;
        cmd = 4'h6; addr = 32'h2000; len = 3; GNT = 0; start = 1;
        tick(); start = 0;
        chk("t2_req", REQ, 0);
        tick();
        chk("t2_addr", ad_out, 32'h2000);
        chk("t2_cbe", cbe_out, 4'h6);
        DEVSEL = 0; TRDY = 0; ad_in = 32'hA0;
        tick();
        chk("t2_irdy", IRDY_out, 0);
        chk("t2_turnaround_ad_oe", ad_oe, 0);
        chk("t2_rv0", rd_valid, 0);
        tick();
        chk("t2_rv_a0", rd_valid, 1);
        chk("t2_rd_a0", rd_data, 32'hA0);
        TRDY = 1; ad_in = 32'hA1;
        tick();
        chk("t2_wait1_irdy", IRDY_out, 0);
        chk("t2_wait1_rv", rd_valid, 0);
        tick();
        chk("t2_wait2_irdy", IRDY_out, 0);
        chk("t2_wait2_hold", rd_data, 32'hA0);
        TRDY = 0;
        tick();
        chk("t2_rv_a1", rd_valid, 1);
        chk("t2_rd_a1", rd_data, 32'hA1);
        chk("t2_frame_mid", FRAME_out, 0);
        ad_in = 32'hA2;
        tick();
        chk("t2_rd_a2", rd_data, 32'hA2);
        chk("t2_frame_last", FRAME_out, 1);
        ad_in = 32'hA3;
        tick();
        chk("t2_rd_a3", rd_data, 32'hA3);
        chk("t2_turn_irdy", IRDY_out, 1);
        TRDY = 1; DEVSEL = 1; GNT = 1;
        tick();
        chk("t2_done", done, 1);
        chk("t2_status", status, 2'b00);
        chk("t2_rd_count", n_rd - b_rd, 4);
        tick();

        // bus busy when grant arrives
        cmd = 4'h7; addr = 32'h3000; len = 0; wr_data = 32'hCAFE0003;
        GNT = 0; FRAME_in = 0; start = 1;
        tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_frame_busy", FRAME_out, 1);
            chk("t3_req_held", REQ, 0);
        end
        FRAME_in = 1; IRDY_in = 0;
        tick();
        chk("t3_irdy_busy", FRAME_out, 1);
        IRDY_in = 1;
        tick();
        chk("t3_addr_frame", FRAME_out, 0);
        chk("t3_addr", ad_out, 32'h3000);
        GNT = 1; DEVSEL = 0; TRDY = 0;
        tick();
        chk("t3_pop", wr_pop, 1);
        chk("t3_data", ad_out, 32'hCAFE0003);
        tick();
        DEVSEL = 1; TRDY = 1;
        wait_done(4);
        chk("t3_status", status, 2'b00);
        tick();

        // target stop on phase 3 of an 8-phase write
        b_pop = n_pop;
        cmd = 4'h7; addr = 32'h4000; len = 7; wr_data = 32'hB0; GNT = 0; start = 1;
        tick(); start = 0;
        tick();
        chk("t4_addr_frame", FRAME_out, 0);
        DEVSEL = 0; TRDY = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_pop", wr_pop, 1);
            chk("t4_data", ad_out, 32'hB0 + i);
            wr_data = wr_data + 1;
        end
        tick();
        chk("t4_pop3", wr_pop, 1);
        chk("t4_data3", ad_out, 32'hB2);
        STOP = 0;
        tick();
        chk("t4_turn_pop", wr_pop, 0);
        chk("t4_turn_frame", FRAME_out, 1);
        STOP = 1; TRDY = 1; DEVSEL = 1; GNT = 1;
        tick();
        chk("t4_done", done, 1);
        chk("t4_status", status, 2'b10);
        chk("t4_pops", n_pop - b_pop, 3);
        tick();

        // zero-wait 16-phase write
        b_pop = n_pop; b_fl = n_fl; b_il = n_il;
        cmd = 4'h7; addr = 32'h5000; len = 15; wr_data = 32'h100; GNT = 0; start = 1;
        tick(); start = 0;
        tick();
        GNT = 1; DEVSEL = 0; TRDY = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t5_data", ad_out, 32'h100 + i);
            wr_data = wr_data + 1;
        end
        tick();
        DEVSEL = 1; TRDY = 1;
        chk("t5_turn_frame", FRAME_out, 1);
        tick();
        chk("t5_done", done, 1);
        chk("t5_status", status, 2'b00);
        chk("t5_pops", n_pop - b_pop, 16);
        chk("t5_frame_cycles", n_fl - b_fl, 16);
        chk("t5_irdy_cycles", n_il - b_il, 16);
        tick();

`ifdef PCI_INIT_MASTER_ABORT_EN
        // no target claims the address
        b_pop = n_pop; b_rd = n_rd;
        cmd = 4'h7; addr = 32'h6000; len = 3; GNT = 0; DEVSEL = 1; TRDY = 1; start = 1;
        tick(); start = 0;
        tick();
        chk("t6_addr_frame", FRAME_out, 0);
        GNT = 1;
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("t6_frame_wait", FRAME_out, 0);
        end
        tick();
        chk("t6_frame_drop", FRAME_out, 1);
        chk("t6_irdy_drop", IRDY_out, 1);
        tick();
        chk("t6_done", done, 1);
        chk("t6_status", status, 2'b01);
        chk("t6_no_pop", n_pop - b_pop, 0);
        chk("t6_no_rd", n_rd - b_rd, 0);
        tick();
`endif

        // asynchronous reset in the middle of a burst
        cmd = 4'h7; addr = 32'h7000; len = 7; GNT = 0; DEVSEL = 0; TRDY = 1; start = 1;
        tick(); start = 0;
        tick();
        tick();
        chk("t7_fi_oe", fi_oe, 1);
        chk("t7_ad_oe", ad_oe, 1);
        #2 rst_n = 0;
        #1;
        chk("t7_rst_fi_oe", fi_oe, 0);
        chk("t7_rst_ad_oe", ad_oe, 0);
        chk("t7_rst_req", REQ, 1);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_frame", FRAME_out, 1);
        chk("t7_rst_irdy", IRDY_out, 1);
        GNT = 1; DEVSEL = 1;
        tick();
        rst_n = 1;
        tick();
        chk("t7_post_req", REQ, 1);
        chk("t7_post_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
